io_write_credit_fifo: RTL and testbench
=======================================

// Module: io_write_credit_fifo
// PURPOSE
//  Parametrised successor to the I/O write path: decodes I/O write addresses, maps ALU writes onto RAM
//  or onto per-port output FIFOs, and replaces the single Empty/Full bit with credit-based flow control.
//  Sits between the ALU output and the I/O write ports. Multiple in-flight writes per port are absorbed
//  without stalling the thread pipeline.
// PARAMETERS
//  WORD_WIDTH         36  data word width
//  ADDR_WIDTH         10  write address width
//  PORT_COUNT          4  number of I/O write ports (1..16)
//  PORT_BASE_ADDR   1020  first I/O write port address; ports are contiguous
//  PORT_ADDR_WIDTH     2  address bits selecting a port (2**PORT_ADDR_WIDTH >= PORT_COUNT)
//  FIFO_DEPTH          4  entries per port FIFO; power of two, >= 2
//  FIFO_ADDR_WIDTH     2  log2(FIFO_DEPTH)
// PORTS
//  clock             in   1                     single clock, all logic posedge
//  reset_n           in   1                     synchronous, active-low reset
//  addr_raw          in   ADDR_WIDTH            Stage 1 raw write address
//  IO_ready          in   1                     thread may issue this cycle (0 = annulled)
//  ALU_result        in   WORD_WIDTH            write data from ALU
//  ALU_addr          in   ADDR_WIDTH            write address from ALU
//  ALU_write_is_IO   in   1                     write_is_IO returning through the ALU
//  ALU_wren          in   1                     write enable from ALU
//  write_is_IO       out  1                     reservation made; carried around pipeline
//  port_ready_masked out  1                     1 if addr_raw is not I/O, or its port had a credit
//  data_RAM          out  WORD_WIDTH            registered RAM write data
//  addr_RAM          out  ADDR_WIDTH            registered RAM write address
//  wren_RAM          out  1                     registered RAM write enable
//  port_data         out  PORT_COUNT*WORD_WIDTH FIFO head per port, port 0 in LSBs
//  port_valid        out  PORT_COUNT            FIFO non-empty per port
//  port_pop          in   PORT_COUNT            consumer accepts head; ignored when port_valid=0
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): all FIFOs empty, credits=FIFO_DEPTH, every output 0, pipeline regs 0.
//  Reset mid-operation discards queued data and reservations with no partial effect.
//  Decode: addr_raw is I/O iff PORT_BASE_ADDR <= addr_raw < PORT_BASE_ADDR+PORT_COUNT; idx = offset.
//  Check (cycle T=addr_raw): port_ready_masked at T+1 = !is_IO | (credit[idx] != 0).
//  Reserve: at T, if is_IO & IO_ready & credit[idx]!=0 then credit[idx]-- ; write_is_IO=1 at T+2.
//   No credit or IO_ready=0: no reservation, write_is_IO=0 at T+2.
//  Commit (cycle C=ALU inputs): data_RAM/addr_RAM/wren_RAM register ALU inputs, valid at C+1.
//   ALU_write_is_IO & ALU_wren: push ALU_result to FIFO[ALU_addr-PORT_BASE_ADDR]; port_valid at C+1.
//   ALU_write_is_IO & !ALU_wren: release, credit[idx]++ (cancelled write returns its credit).
//   wren_RAM follows ALU_wren regardless; RAM ignores I/O-range addresses.
//  Pop: port_pop[i] & port_valid[i] advances head; credit[i]++ same edge.
//  Credit counter FIFO_ADDR_WIDTH+1 bits, range 0..FIFO_DEPTH; credit+occupancy+in-flight = FIFO_DEPTH.
//  Simultaneous events on one port: reserve+pop and/or reserve+release: net sum applied once;
//   push+pop on full FIFO: legal, occupancy unchanged; push+pop on empty: word not bypassed,
//   appears at C+1. Pointers wrap modulo FIFO_DEPTH.
//  port_data for an empty port holds last head value (undefined after reset = 0).
// CONFIGURATION
//  IO_WRITE_FIFO_ERR_EN defined: adds output err_overflow [PORT_COUNT], sticky, cleared only by reset;
//   set when a push targets a full FIFO or a pop/release would exceed credit FIFO_DEPTH. Word dropped.
//  Undefined: port absent; push to a full FIFO is dropped silently, no other state change.
// TESTING
//  1 reset_n=0 2 cycles -> all outputs 0, credit=4 each port, port_valid=0.
//  2 4 reserves to addr 1021 (IO_ready=1), no pops -> port_ready_masked 1,1,1,1 then 5th -> 0,
//    write_is_IO=0 for the 5th; commits fill FIFO1, port_valid[1]=1, data in order.
//  3 FIFO1 full, port_pop[1]=1 same cycle as 5th reserve -> reserve succeeds, credit stays 0.
//  4 reserve to 1022 then ALU_write_is_IO=1, ALU_wren=0 -> no push, credit[2] returns to 4.
//  5 ALU_addr=0x010, ALU_wren=1, ALU_write_is_IO=0 -> wren_RAM=1, addr_RAM=0x010 at C+1, no FIFO push.
//  6 ERR_EN: force push with ALU_write_is_IO to full FIFO0 -> err_overflow[0]=1 sticky, FIFO unchanged.

Source files
------------

// File: rtl/io_write_credit_fifo.sv
// I/O write path with per-port output FIFOs and credit-based flow control.
// Define IO_WRITE_FIFO_ERR_EN to add the sticky per-port err_overflow output.
module io_write_credit_fifo #(
    parameter int unsigned WORD_WIDTH      = 36,
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter int unsigned PORT_COUNT      = 4,
    parameter int unsigned PORT_BASE_ADDR  = 1020,
    parameter int unsigned PORT_ADDR_WIDTH = 2,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned FIFO_ADDR_WIDTH = 2
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [ADDR_WIDTH-1:0]            addr_raw,
    input  logic                             IO_ready,
    input  logic [WORD_WIDTH-1:0]            ALU_result,
    input  logic [ADDR_WIDTH-1:0]            ALU_addr,
    input  logic                             ALU_write_is_IO,
    input  logic                             ALU_wren,
    output logic                             write_is_IO,
    output logic                             port_ready_masked,
    output logic [WORD_WIDTH-1:0]            data_RAM,
    output logic [ADDR_WIDTH-1:0]            addr_RAM,
    output logic                             wren_RAM,
    output logic [PORT_COUNT*WORD_WIDTH-1:0] port_data,
    output logic [PORT_COUNT-1:0]            port_valid,
    input  logic [PORT_COUNT-1:0]            port_pop
`ifdef IO_WRITE_FIFO_ERR_EN
    ,
    output logic [PORT_COUNT-1:0]            err_overflow
`endif
);

    localparam int unsigned CW = FIFO_ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] BaseExt = (ADDR_WIDTH+1)'(PORT_BASE_ADDR);
    localparam logic [ADDR_WIDTH:0] EndExt  = (ADDR_WIDTH+1)'(PORT_BASE_ADDR + PORT_COUNT);
    localparam logic [CW-1:0]       DepthCnt = CW'(FIFO_DEPTH);
    localparam logic [CW:0]         DepthExt = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]       FullXor  = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};

    function automatic logic is_port(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} >= BaseExt) && ({1'b0, a} < EndExt);
    endfunction

    function automatic logic [PORT_ADDR_WIDTH-1:0] port_idx(input logic [ADDR_WIDTH-1:0] a);
        return PORT_ADDR_WIDTH'(a - ADDR_WIDTH'(PORT_BASE_ADDR));
    endfunction

    logic [CW-1:0]         credit_q [PORT_COUNT];
    logic [CW-1:0]         credit_d [PORT_COUNT];
    logic [CW:0]           sum_w    [PORT_COUNT];
    logic [CW-1:0]         wptr_q   [PORT_COUNT];
    logic [CW-1:0]         wptr_d   [PORT_COUNT];
    logic [CW-1:0]         rptr_q   [PORT_COUNT];
    logic [CW-1:0]         rptr_d   [PORT_COUNT];
    logic [WORD_WIDTH-1:0] head_q   [PORT_COUNT];
    logic [WORD_WIDTH-1:0] head_d   [PORT_COUNT];
    logic [WORD_WIDTH-1:0] mem_q    [PORT_COUNT][FIFO_DEPTH];

    logic [PORT_COUNT-1:0] pop_fire, push_req, push_fire, rel, res, full, empty;
    logic                  raw_is_io, alu_is_io, avail, reserve, ready_d;
    logic [PORT_ADDR_WIDTH-1:0] raw_idx, alu_idx;

    logic                  ready_q, res1_q, res2_q, wren_ram_q;
    logic [WORD_WIDTH-1:0] data_ram_q;
    logic [ADDR_WIDTH-1:0] addr_ram_q;

    always_comb begin
        raw_is_io = is_port(addr_raw);
        raw_idx   = port_idx(addr_raw);
        alu_is_io = ALU_write_is_IO && is_port(ALU_addr);
        alu_idx   = port_idx(ALU_addr);
        pop_fire  = '0;
        push_req  = '0;
        push_fire = '0;
        rel       = '0;
        res       = '0;
        full      = '0;
        empty     = '0;
        avail     = 1'b0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            empty[i]     = (wptr_q[i] == rptr_q[i]);
            full[i]      = ((wptr_q[i] ^ rptr_q[i]) == FullXor);
            pop_fire[i]  = port_pop[i] && !empty[i];
            push_req[i]  = alu_is_io && ALU_wren && (alu_idx == PORT_ADDR_WIDTH'(i));
            // A full FIFO still accepts a push when its head leaves on the same edge.
            push_fire[i] = push_req[i] && (!full[i] || pop_fire[i]);
            rel[i]       = alu_is_io && !ALU_wren && (alu_idx == PORT_ADDR_WIDTH'(i));
        end
        // Credits returned this edge can be handed straight back to a new reservation.
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (raw_is_io && (raw_idx == PORT_ADDR_WIDTH'(i))) begin
                avail = (credit_q[i] != '0) || pop_fire[i] || rel[i];
            end
        end
        reserve = raw_is_io && IO_ready && avail;
        ready_d = !raw_is_io || avail;
        for (int i = 0; i < PORT_COUNT; i++) begin
            res[i] = reserve && (raw_idx == PORT_ADDR_WIDTH'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < PORT_COUNT; i++) begin
            sum_w[i] = {1'b0, credit_q[i]} + (CW+1)'(pop_fire[i]) + (CW+1)'(rel[i])
                       - (CW+1)'(res[i]);
            credit_d[i] = (sum_w[i] > DepthExt) ? DepthCnt : sum_w[i][CW-1:0];
            wptr_d[i]   = wptr_q[i] + CW'(push_fire[i]);
            rptr_d[i]   = rptr_q[i] + CW'(pop_fire[i]);
            head_d[i]   = head_q[i];
            if (wptr_d[i] != rptr_d[i]) begin
                if (push_fire[i] &&
                    (rptr_d[i][FIFO_ADDR_WIDTH-1:0] == wptr_q[i][FIFO_ADDR_WIDTH-1:0])) begin
                    head_d[i] = ALU_result;
                end else begin
                    head_d[i] = mem_q[i][rptr_d[i][FIFO_ADDR_WIDTH-1:0]];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ready_q    <= 1'b0;
            res1_q     <= 1'b0;
            res2_q     <= 1'b0;
            wren_ram_q <= 1'b0;
            data_ram_q <= '0;
            addr_ram_q <= '0;
            for (int i = 0; i < PORT_COUNT; i++) begin
                credit_q[i] <= DepthCnt;
                wptr_q[i]   <= '0;
                rptr_q[i]   <= '0;
                head_q[i]   <= '0;
                for (int j = 0; j < FIFO_DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
        end else begin
            ready_q    <= ready_d;
            res1_q     <= reserve;
            res2_q     <= res1_q;
            wren_ram_q <= ALU_wren;
            data_ram_q <= ALU_result;
            addr_ram_q <= ALU_addr;
            for (int i = 0; i < PORT_COUNT; i++) begin
                credit_q[i] <= credit_d[i];
                wptr_q[i]   <= wptr_d[i];
                rptr_q[i]   <= rptr_d[i];
                head_q[i]   <= head_d[i];
                if (push_fire[i]) begin
                    mem_q[i][wptr_q[i][FIFO_ADDR_WIDTH-1:0]] <= ALU_result;
                end
            end
        end
    end

`ifdef IO_WRITE_FIFO_ERR_EN
    logic [PORT_COUNT-1:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        for (int i = 0; i < PORT_COUNT; i++) begin
            if ((push_req[i] && !push_fire[i]) || (sum_w[i] > DepthExt)) begin
                err_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_overflow = err_q;
`endif

    always_comb begin
        for (int i = 0; i < PORT_COUNT; i++) begin
            port_data[i*WORD_WIDTH +: WORD_WIDTH] = head_q[i];
            port_valid[i] = !empty[i];
        end
    end

    assign port_ready_masked = ready_q;
    assign write_is_IO       = res2_q;
    assign wren_RAM          = wren_ram_q;
    assign data_RAM          = data_ram_q;
    assign addr_RAM          = addr_ram_q;

endmodule

// File: tb/tb_io_write_credit_fifo.sv
// Directed bench for io_write_credit_fifo: reservation, commit, pop, release and reset paths.
// Define IO_WRITE_FIFO_ERR_EN to also check the err_overflow output.
module tb_io_write_credit_fifo;

    localparam int W = 36;
    localparam int A = 10;
    localparam int P = 4;

    logic           clock = 1'b0;
    logic           reset_n;
    logic [A-1:0]   addr_raw;
    logic           IO_ready;
    logic [W-1:0]   ALU_result;
    logic [A-1:0]   ALU_addr;
    logic           ALU_write_is_IO;
    logic           ALU_wren;
    logic           write_is_IO;
    logic           port_ready_masked;
    logic [W-1:0]   data_RAM;
    logic [A-1:0]   addr_RAM;
    logic           wren_RAM;
    logic [P*W-1:0] port_data;
    logic [P-1:0]   port_valid;
    logic [P-1:0]   port_pop;
`ifdef IO_WRITE_FIFO_ERR_EN
    logic [P-1:0]   err_overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] base0 = 36'h5_1234_0000;
    logic [W-1:0] base1 = 36'h9_abcd_0000;

    io_write_credit_fifo dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .addr_raw          (addr_raw),
        .IO_ready          (IO_ready),
        .ALU_result        (ALU_result),
        .ALU_addr          (ALU_addr),
        .ALU_write_is_IO   (ALU_write_is_IO),
        .ALU_wren          (ALU_wren),
        .write_is_IO       (write_is_IO),
        .port_ready_masked (port_ready_masked),
        .data_RAM          (data_RAM),
        .addr_RAM          (addr_RAM),
        .wren_RAM          (wren_RAM),
        .port_data         (port_data),
        .port_valid        (port_valid),
        .port_pop          (port_pop)
`ifdef IO_WRITE_FIFO_ERR_EN
        ,
        .err_overflow      (err_overflow)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        addr_raw        = '0;
        IO_ready        = 1'b0;
        ALU_result      = '0;
        ALU_addr        = '0;
        ALU_write_is_IO = 1'b0;
        ALU_wren        = 1'b0;
        port_pop        = '0;
    endtask

    // One issue cycle followed by one idle cycle; checks ready at T+1 and write_is_IO at T+2.
    task automatic reserve(input int addr, input logic rdy, input logic [P-1:0] pop,
                           input logic exp_ready, input logic exp_wio, input string tag);
        addr_raw = A'(addr);
        IO_ready = rdy;
        port_pop = pop;
        tick();
        check_eq({tag, "_ready"}, 64'(port_ready_masked), 64'(exp_ready));
        idle();
        tick();
        check_eq({tag, "_wio"}, 64'(write_is_IO), 64'(exp_wio));
    endtask

    task automatic commit(input int addr, input logic is_io, input logic wren,
                          input logic [W-1:0] data, input logic [P-1:0] pop);
        ALU_addr        = A'(addr);
        ALU_write_is_IO = is_io;
        ALU_wren        = wren;
        ALU_result      = data;
        port_pop        = pop;
        tick();
        idle();
    endtask

    task automatic pop(input logic [P-1:0] mask);
        port_pop = mask;
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        tick();
        tick();
        check_eq("rst_wio", 64'(write_is_IO), 64'd0);
        check_eq("rst_ready", 64'(port_ready_masked), 64'd0);
        check_eq("rst_data_ram", 64'(data_RAM), 64'd0);
        check_eq("rst_addr_ram", 64'(addr_RAM), 64'd0);
        check_eq("rst_wren_ram", 64'(wren_RAM), 64'd0);
        check_eq("rst_valid", 64'(port_valid), 64'd0);
        check_eq("rst_pdata_lo", port_data[63:0], 64'd0);
        check_eq("rst_pdata_hi", 64'(port_data[P*W-1:64]), 64'd0);
`ifdef IO_WRITE_FIFO_ERR_EN
        check_eq("rst_err", 64'(err_overflow), 64'd0);
`endif
        reset_n = 1'b1;

        // Port 1: four credits, then exhausted.
        for (int k = 0; k < 4; k++) reserve(1021, 1'b1, '0, 1'b1, 1'b1, "res1");
        reserve(1021, 1'b1, '0, 1'b0, 1'b0, "res1_5th");
        for (int k = 0; k < 4; k++) begin
            commit(1021, 1'b1, 1'b1, base1 + W'(k), '0);
            check_eq("p1_valid", 64'(port_valid), 64'h2);
            check_eq("p1_head", 64'(port_data[W +: W]), 64'(base1));
            check_eq("p1_wren_ram", 64'(wren_RAM), 64'd1);
            check_eq("p1_addr_ram", 64'(addr_RAM), 64'd1021);
        end

        // Pop on the same edge as a reservation hands the credit over; credit stays 0.
        reserve(1021, 1'b1, 4'b0010, 1'b1, 1'b1, "res_pop");
        check_eq("res_pop_head", 64'(port_data[W +: W]), 64'(base1 + W'(1)));
        reserve(1021, 1'b1, '0, 1'b0, 1'b0, "credit_zero");
        commit(1021, 1'b1, 1'b1, base1 + W'(4), '0);
        for (int k = 1; k <= 4; k++) begin
            check_eq("p1_drain_head", 64'(port_data[W +: W]), 64'(base1 + W'(k)));
            check_eq("p1_drain_valid", 64'(port_valid[1]), 64'd1);
            pop(4'b0010);
        end
        check_eq("p1_empty", 64'(port_valid), 64'd0);
        check_eq("p1_hold", 64'(port_data[W +: W]), 64'(base1 + W'(4)));
        // Pops returned all four credits.
        for (int k = 0; k < 4; k++) reserve(1021, 1'b1, '0, 1'b1, 1'b1, "p1_refill");
        reserve(1021, 1'b1, '0, 1'b0, 1'b0, "p1_refill_5th");
        for (int k = 0; k < 4; k++) commit(1021, 1'b1, 1'b0, '0, '0);

        // Port 2: cancelled write returns its credit.
        reserve(1022, 1'b1, '0, 1'b1, 1'b1, "res2");
        commit(1022, 1'b1, 1'b0, 36'hf_ffff_ffff, '0);
        check_eq("rel_valid", 64'(port_valid), 64'd0);
        check_eq("rel_wren_ram", 64'(wren_RAM), 64'd0);
        for (int k = 0; k < 4; k++) reserve(1022, 1'b1, '0, 1'b1, 1'b1, "p2_credit4");
        reserve(1022, 1'b1, '0, 1'b0, 1'b0, "p2_credit4_5th");
        for (int k = 0; k < 4; k++) commit(1022, 1'b1, 1'b0, '0, '0);

        // Plain RAM write.
        commit(16, 1'b0, 1'b1, 36'h1_2345_6789, '0);
        check_eq("ram_wren", 64'(wren_RAM), 64'd1);
        check_eq("ram_addr", 64'(addr_RAM), 64'h10);
        check_eq("ram_data", 64'(data_RAM), 64'h1_2345_6789);
        check_eq("ram_no_push", 64'(port_valid), 64'd0);

        // Decode boundaries and annulled issue.
        reserve(1019, 1'b1, '0, 1'b1, 1'b0, "below_base");
        reserve(1020, 1'b0, '0, 1'b1, 1'b0, "annulled");
        reserve(1023, 1'b1, '0, 1'b1, 1'b1, "top_port");
        commit(1023, 1'b1, 1'b0, '0, '0);

        // Port 0: forced pushes overfill; fifth word dropped.
        for (int k = 0; k < 4; k++) commit(1020, 1'b1, 1'b1, base0 + W'(k), '0);
        commit(1020, 1'b1, 1'b1, base0 + W'(4), '0);
        check_eq("ovf_valid", 64'(port_valid), 64'd1);
        check_eq("ovf_head", 64'(port_data[W-1:0]), 64'(base0));
`ifdef IO_WRITE_FIFO_ERR_EN
        check_eq("ovf_err", 64'(err_overflow), 64'd1);
`endif
        // Push and pop on a full FIFO: occupancy stays 4.
        commit(1020, 1'b1, 1'b1, base0 + W'(5), 4'b0001);
        for (int k = 1; k <= 4; k++) begin
            check_eq("full_pp_head", 64'(port_data[W-1:0]), 64'(base0 + W'((k == 4) ? 5 : k)));
            pop(4'b0001);
        end
        check_eq("full_pp_empty", 64'(port_valid), 64'd0);
`ifdef IO_WRITE_FIFO_ERR_EN
        check_eq("err_sticky", 64'(err_overflow), 64'd1);
`endif

        // Reset mid-operation discards queued data.
        commit(1023, 1'b1, 1'b1, 36'h3_3333_3333, '0);
        check_eq("pre_rst_valid", 64'(port_valid), 64'h8);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_eq("mid_rst_valid", 64'(port_valid), 64'd0);
        check_eq("mid_rst_pdata", 64'(port_data[P*W-1:3*W]), 64'd0);
`ifdef IO_WRITE_FIFO_ERR_EN
        check_eq("mid_rst_err", 64'(err_overflow), 64'd0);
`endif
        reserve(1023, 1'b1, '0, 1'b1, 1'b1, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
